// File: rtl/sprite_scan_reader_pkg.sv
// Shared constants and types for the sprite scan-out path: sprite geometry,
// visible raster size, SRAM depth and the colour-key value.
package sprite_scan_reader_pkg;

    localparam int SPR_W     = 300;
    localparam int SPR_H     = 54;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int SRAM_DEPTH = SPR_W * SPR_H;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam rgb444_t KEY_COLOR = 12'hF0F;

endpackage

// File: rtl/sprite_window_ctr.sv
// Latches and clamps the sprite position once per frame, decodes whether the
// current raster pixel lies in the sprite window, and walks the read pointer.
module sprite_window_ctr #(
    parameter int ADDR_WIDTH  = 14,
    parameter int COORD_WIDTH = 10,
    parameter int SPR_W       = sprite_scan_reader_pkg::SPR_W,
    parameter int SPR_H       = sprite_scan_reader_pkg::SPR_H,
    parameter int H_ACTIVE    = sprite_scan_reader_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = sprite_scan_reader_pkg::V_ACTIVE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    input  logic                   video_on,
    input  logic [COORD_WIDTH-1:0] pos_x,
    input  logic [COORD_WIDTH-1:0] pos_y,
    output logic                   in_win,
    output logic [ADDR_WIDTH-1:0]  ptr_cur
);

    // One extra bit so that px + SPR_W cannot overflow.
    localparam int CW = COORD_WIDTH + 1;
    localparam logic [CW-1:0] MAX_PX = CW'(H_ACTIVE - SPR_W);
    localparam logic [CW-1:0] MAX_PY = CW'(V_ACTIVE - SPR_H);
    localparam logic [CW-1:0] SPR_W_C = CW'(SPR_W);
    localparam logic [CW-1:0] SPR_H_C = CW'(SPR_H);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = ADDR_WIDTH'(SPR_W * SPR_H - 1);

    logic [CW-1:0]         px_q, py_q;
    logic [CW-1:0]         px_req, py_req;
    logic [CW-1:0]         px_eff, py_eff;
    logic [CW-1:0]         x_ext, y_ext;
    logic                  armed_q, armed_eff;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_nxt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        px_req    = ({1'b0, pos_x} > MAX_PX) ? MAX_PX : {1'b0, pos_x};
        py_req    = ({1'b0, pos_y} > MAX_PY) ? MAX_PY : {1'b0, pos_y};
        // The frame_start pixel itself is decoded against the freshly latched
        // position, so (0,0) can read address 0 on that same cycle.
        px_eff    = frame_start ? px_req : px_q;
        py_eff    = frame_start ? py_req : py_q;
        armed_eff = frame_start | armed_q;
        x_ext     = {1'b0, x};
        y_ext     = {1'b0, y};

        in_win = video_on & armed_eff
               & (x_ext >= px_eff) & (x_ext < px_eff + SPR_W_C)
               & (y_ext >= py_eff) & (y_ext < py_eff + SPR_H_C);

        ptr_cur = frame_start ? '0 : ptr_q;
        ptr_nxt = ptr_cur;
        if (in_win && (ptr_cur != PTR_MAX)) begin
            ptr_nxt = ptr_cur + ADDR_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            ptr_q   <= '0;
        end else begin
            if (frame_start) begin
                armed_q <= 1'b1;
                px_q    <= px_req;
                py_q    <= py_req;
            end
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/sprite_scan_reader.sv
// Reads the sprite SRAM in raster order and composites it over a background
// colour with colour-key transparency; syncs are delayed to match (3 cycles).
module sprite_scan_reader #(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 12,
    parameter int SPR_W       = sprite_scan_reader_pkg::SPR_W,
    parameter int SPR_H       = sprite_scan_reader_pkg::SPR_H,
    parameter int H_ACTIVE    = sprite_scan_reader_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = sprite_scan_reader_pkg::V_ACTIVE,
    parameter int COORD_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR = sprite_scan_reader_pkg::KEY_COLOR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    input  logic                   video_on,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [COORD_WIDTH-1:0] pos_x,
    input  logic [COORD_WIDTH-1:0] pos_y,
    input  logic [DATA_WIDTH-1:0]  bg_rgb,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic                   sram_write,
    input  logic [DATA_WIDTH-1:0]  sram_data,
    output logic [DATA_WIDTH-1:0]  rgb,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   sprite_hit
);

    logic                  in_win;
    logic [ADDR_WIDTH-1:0] ptr_cur;
    logic                  win1, on1, hs1, vs1;
    logic                  win2, on2, hs2, vs2;
    logic                  opaque;

    sprite_window_ctr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .COORD_WIDTH(COORD_WIDTH),
        .SPR_W      (SPR_W),
        .SPR_H      (SPR_H),
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE)
    ) u_window (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .in_win     (in_win),
        .ptr_cur    (ptr_cur)
    );

    assign sram_write = 1'b0;
    assign opaque     = (sram_data != KEY_COLOR);

    // Stage 1 issues the address, stage 2 waits for the SRAM, stage 3 composites.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sram_addr  <= '0;
            win1       <= 1'b0;
            on1        <= 1'b0;
            hs1        <= 1'b0;
            vs1        <= 1'b0;
            win2       <= 1'b0;
            on2        <= 1'b0;
            hs2        <= 1'b0;
            vs2        <= 1'b0;
            rgb        <= '0;
            sprite_hit <= 1'b0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
        end else begin
            sram_addr  <= in_win ? ptr_cur : '0;
            win1       <= in_win;
            on1        <= video_on;
            hs1        <= hsync_in;
            vs1        <= vsync_in;

            win2       <= win1;
            on2        <= on1;
            hs2        <= hs1;
            vs2        <= vs1;

            if (!on2) begin
                rgb <= '0;
            end else if (win2 && opaque) begin
                rgb <= sram_data;
            end else begin
                rgb <= bg_rgb;
            end
            sprite_hit <= on2 & win2 & opaque;
            hsync_out  <= hs2;
            vsync_out  <= vs2;
        end
    end

endmodule

// File: tb/tb_sprite_scan_reader.sv
// Self-checking bench: random SRAM contents and syncs, scripted frames, and a
// queue-based reference model computing addresses as row*SPR_W + col.
module tb_sprite_scan_reader;
    import sprite_scan_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [9:0]  x, y;
    logic        video_on;
    logic        hsync_in, vsync_in;
    logic [9:0]  pos_x, pos_y;
    logic [11:0] bg_rgb;
    logic [13:0] sram_addr;
    logic        sram_write;
    logic [11:0] sram_data;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, sprite_hit;

    logic [11:0] mem [0:SRAM_DEPTH-1];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int x;
        int y;
        int fid;
        bit win;
        bit on;
        bit hs;
        bit vs;
        bit zero;
        int addr;
    } exp_t;

    exp_t q[$];
    exp_t prev;
    bit   prev_valid = 1'b0;
    int   cur_fid = 0;
    bit   m_armed = 1'b0;
    int   m_px = 0;
    int   m_py = 0;

    sprite_scan_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .bg_rgb     (bg_rgb),
        .sram_addr  (sram_addr),
        .sram_write (sram_write),
        .sram_data  (sram_data),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .sprite_hit (sprite_hit)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data valid the cycle after the address is sampled.
    always @(posedge clk) begin
        if (int'(sram_addr) < SRAM_DEPTH) sram_data <= mem[sram_addr];
        else                              sram_data <= 12'hXXX;
    end

    task automatic check(input string tag, input logic [31:0] actual, input int expected);
        tests++;
        if (actual !== 32'(expected)) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // One pixel clock: check outputs due now, then apply new inputs and predict.
    task automatic drive(input int xx, input int yy, input bit on, input bit fs, input bit rn);
        exp_t e;
        exp_t o;
        int   pix;
        int   erg;
        int   ehit;
        @(negedge clk);
        if (prev_valid) begin
            check("sram_addr", sram_addr, prev.addr);
            if (prev.fid == 1 && prev.y == 0 && prev.x == 0)   check("addr_f1_0_0", sram_addr, 0);
            if (prev.fid == 1 && prev.y == 0 && prev.x == 299) check("addr_f1_299_0", sram_addr, 299);
            if (prev.fid == 1 && prev.y == 0 && prev.x == 300) check("addr_f1_300_0", sram_addr, 0);
            if (prev.fid == 1 && prev.y == 1 && prev.x == 0)   check("addr_f1_0_1", sram_addr, 300);
            if (prev.fid == 1 && prev.y == 53 && prev.x == 299) check("addr_f1_299_53", sram_addr, 16199);
            if (prev.fid == 3 && prev.y == 479 && prev.x == 639) check("addr_clamp_639_479", sram_addr, 16199);
            if (prev.fid == 3 && prev.y == 426 && prev.x == 340) check("addr_clamp_340_426", sram_addr, 0);
            if (prev.fid == 3 && prev.y == 426 && prev.x == 339) check("addr_clamp_339_426", sram_addr, 0);
            if (prev.fid == 5 && prev.y == 0 && prev.x == 0)   check("addr_restart_0_0", sram_addr, 0);
            if (prev.fid == 5 && prev.y == 0 && prev.x == 1)   check("addr_restart_1_0", sram_addr, 1);
        end
        check("sram_write", sram_write, 0);
        if (q.size() >= 3) begin
            o = q.pop_front();
            if (o.zero) begin
                erg  = 0;
                ehit = 0;
            end else begin
                pix  = int'(mem[o.addr]);
                ehit = (o.on && o.win && pix != int'(KEY_COLOR)) ? 1 : 0;
                erg  = !o.on ? 0 : (ehit != 0) ? pix : int'(bg_rgb);
            end
            check("rgb", rgb, erg);
            check("sprite_hit", sprite_hit, ehit);
            check("hsync_out", hsync_out, o.zero ? 0 : int'(o.hs));
            check("vsync_out", vsync_out, o.zero ? 0 : int'(o.vs));
            if (!o.on) check("blank_rgb", rgb, 0);
            if (o.fid == 1 && o.x == 0 && o.y == 0) begin
                check("key_rgb_0_0", rgb, 12'h222);
                check("key_hit_0_0", sprite_hit, 0);
            end
            if (o.fid == 2 && o.x == 15 && o.y == 20) begin
                check("comp_rgb_15_20", rgb, 12'h0A3);
                check("comp_hit_15_20", sprite_hit, 1);
            end
            if (o.fid == 2 && o.x == 9 && o.y == 20) begin
                check("comp_rgb_9_20", rgb, 12'h111);
                check("comp_hit_9_20", sprite_hit, 0);
            end
        end

        x           = 10'(xx);
        y           = 10'(yy);
        video_on    = on;
        frame_start = fs;
        rst_n       = rn;
        hsync_in    = 1'($urandom);
        vsync_in    = 1'($urandom);

        e.x = xx; e.y = yy; e.fid = cur_fid;
        e.on = on; e.hs = hsync_in; e.vs = vsync_in;
        e.zero = 1'b0; e.win = 1'b0; e.addr = 0;
        if (!rn) begin
            m_armed = 1'b0;
            for (int i = 0; i < q.size(); i++) q[i].zero = 1'b1;
            e.zero = 1'b1;
        end else begin
            if (fs) begin
                m_armed = 1'b1;
                m_px = (int'(pos_x) > H_ACTIVE - SPR_W) ? H_ACTIVE - SPR_W : int'(pos_x);
                m_py = (int'(pos_y) > V_ACTIVE - SPR_H) ? V_ACTIVE - SPR_H : int'(pos_y);
            end
            e.win = on && m_armed && xx >= m_px && xx < m_px + SPR_W
                    && yy >= m_py && yy < m_py + SPR_H;
            e.addr = e.win ? (yy - m_py) * SPR_W + (xx - m_px) : 0;
        end
        q.push_back(e);
        prev       = e;
        prev_valid = 1'b1;
    endtask

    // Raster over the sprite window plus a margin; pos changes mid-frame.
    task automatic run_frame(input int fid, input int req_x, input int req_y, input int bg_val,
                             input int rx, input int ry, input int max_row);
        int cpx, cpy, ylo, yhi, xlo, xhi;
        cur_fid = fid;
        pos_x   = 10'(req_x);
        pos_y   = 10'(req_y);
        bg_rgb  = 12'(bg_val);
        cpx = (req_x > H_ACTIVE - SPR_W) ? H_ACTIVE - SPR_W : req_x;
        cpy = (req_y > V_ACTIVE - SPR_H) ? V_ACTIVE - SPR_H : req_y;
        ylo = (cpy > 0) ? cpy - 1 : 0;
        yhi = cpy + SPR_H;
        if (yhi > V_ACTIVE - 1) yhi = V_ACTIVE - 1;
        if (yhi > max_row) yhi = max_row;
        xlo = (cpx >= 2) ? cpx - 2 : 0;
        xhi = cpx + SPR_W + 1;
        if (xhi > H_ACTIVE - 1) xhi = H_ACTIVE - 1;

        drive(0, 0, 1'b1, 1'b1, 1'b1);
        for (int yy = ylo; yy <= yhi; yy++) begin
            if (yy == cpy + 10) begin
                pos_x = 10'($urandom_range(0, 639));
                pos_y = 10'($urandom_range(0, 479));
            end
            for (int xx = xlo; xx <= xhi; xx++) begin
                if (xx == 0 && yy == 0) continue;
                drive(xx, yy, 1'b1, 1'b0, !(xx == rx && yy == ry));
            end
            for (int k = 0; k < 2; k++) drive(H_ACTIVE + k, yy, 1'b0, 1'b0, 1'b1);
        end
        for (int k = 0; k < 4; k++) drive(700, 500, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < SRAM_DEPTH; i++) begin
            mem[i] = ($urandom_range(0, 15) == 0) ? KEY_COLOR : 12'($urandom);
        end
        mem[0] = 12'hF0F;
        mem[5] = 12'h0A3;

        rst_n = 1'b0; frame_start = 1'b0; x = '0; y = '0; video_on = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0; pos_x = '0; pos_y = '0; bg_rgb = 12'h333;

        // Reset during active video; frame_start coinciding with reset is ignored.
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(0, 0, 1'b1, 1'b1, 1'b0);
            else        drive(100 + i, 30, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) drive(i, 0, 1'b1, 1'b0, 1'b1);

        run_frame(1, 0, 0, 12'h222, -1, -1, 1000);
        run_frame(2, 10, 20, 12'h111, -1, -1, 1000);
        run_frame(3, 500, 470, int'($urandom_range(0, 4095)), -1, -1, 1000);
        run_frame(4, 0, 0, int'($urandom_range(0, 4095)), 100, 30, 40);
        run_frame(5, 0, 0, int'($urandom_range(0, 4095)), -1, -1, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
